// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the EX/MEM memory access unit: state encoding and default widths.
package mem_access_unit_pkg;

  localparam int DEF_PROC_DATA_WIDTH        = 16;
  localparam int DEF_PROC_REGFILE_LOG2_DEEP = 5;
  localparam int DEF_DMEM_ADDR_WIDTH        = 8;
  localparam int THREAD_ID_WIDTH            = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/mem_access_unit_timeout_ctr.sv
// Saturating up-counter for the memory transaction watchdog; tc_o flags the last allowed cycle.
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == TC_VAL);

  // Saturation keeps tc_o asserted if a load is granted on the terminal cycle,
  // so the following WAIT cycle is still treated as the last one.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// EX/MEM consumer: runs loads/stores over a req/gnt/rvalid data-memory handshake,
// passes ALU results through, and produces the registered writeback bundle.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int PROC_DATA_WIDTH        = DEF_PROC_DATA_WIDTH,
  parameter int PROC_REGFILE_LOG2_DEEP = DEF_PROC_REGFILE_LOG2_DEEP,
  parameter int DMEM_ADDR_WIDTH        = DEF_DMEM_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES         = 15
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic                              reg_write_en_i,
  input  logic                              mem_write_en_i,
  input  logic                              mem_read_en_i,
  input  logic                              mem_to_reg_i,
  input  logic [PROC_DATA_WIDTH-1:0]        alu_i,
  input  logic [PROC_DATA_WIDTH-1:0]        reg_data2_i,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] reg_write_addr_i,
  input  logic [1:0]                        thread_id_i,
  output logic                              stall_o,
  output logic                              dmem_req_o,
  output logic                              dmem_we_o,
  output logic [DMEM_ADDR_WIDTH-1:0]        dmem_addr_o,
  output logic [PROC_DATA_WIDTH-1:0]        dmem_wdata_o,
  input  logic                              dmem_gnt_i,
  input  logic                              dmem_rvalid_i,
  input  logic [PROC_DATA_WIDTH-1:0]        dmem_rdata_i,
  output logic                              reg_write_en_o,
  output logic [PROC_REGFILE_LOG2_DEEP-1:0] reg_write_addr_o,
  output logic [PROC_DATA_WIDTH-1:0]        reg_write_data_o,
  output logic [1:0]                        thread_id_o,
  output logic                              err_o,
  output logic [1:0]                        err_thread_o
);

  state_e state_q, state_d;

  logic                              h_we_q, h_we_d;
  logic                              h_rwe_q, h_rwe_d;
  logic                              h_m2r_q, h_m2r_d;
  logic [PROC_DATA_WIDTH-1:0]        h_alu_q, h_alu_d;
  logic [PROC_DATA_WIDTH-1:0]        h_wdata_q, h_wdata_d;
  logic [PROC_REGFILE_LOG2_DEEP-1:0] h_waddr_q, h_waddr_d;
  logic [1:0]                        h_tid_q, h_tid_d;

  logic                              wb_en_q, wb_en_d;
  logic [PROC_REGFILE_LOG2_DEEP-1:0] wb_addr_q, wb_addr_d;
  logic [PROC_DATA_WIDTH-1:0]        wb_data_q, wb_data_d;
  logic [1:0]                        wb_tid_q, wb_tid_d;
  logic                              err_q, err_d;
  logic [1:0]                        err_tid_q, err_tid_d;

  logic tmo_tc;

  mem_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .clr_i  (state_q == ST_IDLE),
    .en_i   (state_q != ST_IDLE),
    .tc_o   (tmo_tc)
  );

  assign stall_o      = (state_q != ST_IDLE);
  assign dmem_req_o   = (state_q == ST_REQ);
  assign dmem_we_o    = h_we_q;
  assign dmem_addr_o  = h_alu_q[DMEM_ADDR_WIDTH-1:0];
  assign dmem_wdata_o = h_wdata_q;

  assign reg_write_en_o   = wb_en_q;
  assign reg_write_addr_o = wb_addr_q;
  assign reg_write_data_o = wb_data_q;
  assign thread_id_o      = wb_tid_q;
  assign err_o            = err_q;
  assign err_thread_o     = err_tid_q;

  always_comb begin
    state_d   = state_q;
    h_we_d    = h_we_q;
    h_rwe_d   = h_rwe_q;
    h_m2r_d   = h_m2r_q;
    h_alu_d   = h_alu_q;
    h_wdata_d = h_wdata_q;
    h_waddr_d = h_waddr_q;
    h_tid_d   = h_tid_q;
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    wb_tid_d  = wb_tid_q;
    err_d     = err_q;
    err_tid_d = err_tid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (mem_read_en_i || mem_write_en_i) begin
          // Read+write together is resolved as a store.
          h_we_d    = mem_write_en_i;
          h_rwe_d   = reg_write_en_i;
          h_m2r_d   = mem_to_reg_i;
          h_alu_d   = alu_i;
          h_wdata_d = reg_data2_i;
          h_waddr_d = reg_write_addr_i;
          h_tid_d   = thread_id_i;
          state_d   = ST_REQ;
        end else begin
          wb_en_d   = reg_write_en_i;
          wb_addr_d = reg_write_addr_i;
          wb_data_d = alu_i;
          wb_tid_d  = thread_id_i;
        end
      end
      ST_REQ: begin
        if (dmem_gnt_i) begin
          if (h_we_q) begin
            state_d   = ST_IDLE;
            wb_en_d   = h_rwe_q;
            wb_addr_d = h_waddr_q;
            wb_data_d = h_alu_q;
            wb_tid_d  = h_tid_q;
          end else begin
            state_d = ST_WAIT;
          end
        end else if (tmo_tc) begin
          state_d   = ST_IDLE;
          err_d     = 1'b1;
          err_tid_d = h_tid_q;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid_i) begin
          state_d   = ST_IDLE;
          wb_en_d   = h_rwe_q;
          wb_addr_d = h_waddr_q;
          wb_data_d = h_m2r_q ? dmem_rdata_i : h_alu_q;
          wb_tid_d  = h_tid_q;
        end else if (tmo_tc) begin
          state_d   = ST_IDLE;
          err_d     = 1'b1;
          err_tid_d = h_tid_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      h_we_q    <= 1'b0;
      h_rwe_q   <= 1'b0;
      h_m2r_q   <= 1'b0;
      h_alu_q   <= '0;
      h_wdata_q <= '0;
      h_waddr_q <= '0;
      h_tid_q   <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      wb_tid_q  <= '0;
      err_q     <= 1'b0;
      err_tid_q <= '0;
    end else begin
      state_q   <= state_d;
      h_we_q    <= h_we_d;
      h_rwe_q   <= h_rwe_d;
      h_m2r_q   <= h_m2r_d;
      h_alu_q   <= h_alu_d;
      h_wdata_q <= h_wdata_d;
      h_waddr_q <= h_waddr_d;
      h_tid_q   <= h_tid_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      wb_tid_q  <= wb_tid_d;
      err_q     <= err_d;
      err_tid_q <= err_tid_d;
    end
  end

endmodule
